icache_mem_responder: RTL and testbench

Memory-side responder for the instruction-cache ↔ memory interface. It accepts single-word requests (`mem_req_type` fields) from the cache controller and services them against a word-addressed backing array after a fixed, parameterised latency. It returns read data or a write acknowledge through `mem_data_type` fields. It is the memory end of the same protocol the cache controller initiates; a 64-bit line fill or writeback is two consecutive word requests issued by the cache.

---
 rtl/icache_mem_responder.sv | 123 ++++++++++++
 tb/tb_icache_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_responder.sv
// Memory-side responder for the instruction-cache <-> memory interface.
// Accepts one word request at a time and answers after LATENCY cycles with
// read data or an echo of the write data. The backing array is word
// addressed; the byte offset is ignored and high address bits alias.
//
// Handshake: a request is taken on any rising edge where the FSM is IDLE
// and mem_req_valid=1. The requester holds valid and fields stable until it
// sees mem_rsp_ready, which is a one-cycle strobe. A new request may be
// presented in the ready cycle and is taken on the edge that ends it.
// Response timing: ready is high in the cycle that starts LATENCY edges
// after acceptance.
module icache_mem_responder #(
  parameter int unsigned LATENCY   = 4,    // 1..255
  parameter int unsigned MEM_WORDS = 4096  // power of two, 2..16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_req_addr,
  input  logic [31:0] mem_req_data,
  input  logic        mem_req_rw,
  input  logic        mem_req_valid,
  output logic [31:0] mem_rsp_data,
  output logic        mem_rsp_ready,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic [7:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_req_idx;
  logic             r_rw;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_ready;
  logic [31:0]      r_mem [MEM_WORDS];
  logic             w_unused_addr;

  // Word index: drop the byte offset, keep the low IDX_W word bits.
  assign w_req_idx     = mem_req_addr[IDX_W+1:2];
  assign w_unused_addr = ^mem_req_addr;

  // Next-state logic; acceptance only happens from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_valid) begin
          w_accept     = 1'b1;
          w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd1) w_next_state = S_RESP;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Latency counter: loaded on acceptance, counts down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_cnt <= 8'd0;
    else if (w_accept)                       r_cnt <= CNT_LOAD;
    else if (r_state == S_WAIT && r_cnt != 0) r_cnt <= r_cnt - 8'd1;
  end

  // Request capture; the read value is taken from the array at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_rw    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_idx   <= w_req_idx;
      r_rw    <= mem_req_rw;
      r_wdata <= mem_req_data;
      r_rdata <= r_mem[w_req_idx];
    end
  end

  // Response strobe and data, registered on the edge that ends RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_ready <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      r_rsp_ready <= (r_state == S_RESP);
      if (r_state == S_RESP) r_rsp_data <= r_rw ? r_wdata : r_rdata;
    end
  end

  // Array write at the end of RESP; reset forces IDLE so a pending write is lost.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_rw) r_mem[r_idx] <= r_wdata;
  end

  assign mem_rsp_data  = r_rsp_data;
  assign mem_rsp_ready = r_rsp_ready;
  assign busy          = (r_state != S_IDLE) || r_rsp_ready;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder: a LATENCY=4 instance for the
// main scenarios and a LATENCY=1 instance for back-to-back timing.
module tb_icache_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        req_rw;
  logic        req_valid;
  logic        req_valid1;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [31:0] rsp_data1;
  logic        rsp_ready1;
  logic        busy1;
  logic [1:0]  dbg_state1;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rdy_cyc = 0;
  logic [31:0] exp_q[$];

  icache_mem_responder #(.LATENCY(LAT), .MEM_WORDS(4096)) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_rw(req_rw), .mem_req_valid(req_valid),
    .mem_rsp_data(rsp_data), .mem_rsp_ready(rsp_ready),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  icache_mem_responder #(.LATENCY(1), .MEM_WORDS(4096)) dut1 (
    .clk(clk), .rst(rst),
    .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_rw(req_rw), .mem_req_valid(req_valid1),
    .mem_rsp_data(rsp_data1), .mem_rsp_ready(rsp_ready1),
    .busy(busy1), .o_dbg_state(dbg_state1)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the ready strobe; lat counts edges since acceptance.
  task automatic wait_ready(input int start, output int lat);
    lat = start;
    while (!rsp_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one request on the LATENCY=4 instance. Call #1 after an edge.
  // hold=1 leaves valid high so the next call is taken back to back.
  task automatic do_req(input string tag, input logic rw, input logic [15:0] addr,
                        input logic [31:0] data, input logic [31:0] expd, input bit hold);
    int lat;
    logic [31:0] e;
    req_rw    = rw;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    exp_q.push_back(expd);
    @(posedge clk); #1;
    wait_ready(0, lat);
    rdy_cyc = cyc;
    chk({tag, "_lat"}, lat, LAT);
    e = exp_q.pop_front();
    chk({tag, "_data"}, rsp_data, e);
    if (!hold) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {31'd0, rsp_ready}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    int c1;
    int pulses;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_valid1 = 1'b0;
    req_rw     = 1'b0;
    req_addr   = 16'h0;
    req_data   = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, rsp_ready}, 32'd0);
    chk("rst_data",  rsp_data, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write/read basic.
    do_req("wr10", 1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_req("rd10", 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0);
    do_req("rd14", 1'b0, 16'h0014, 32'h0,        32'h00000000, 1'b0);

    // Line fill pair, then back-to-back reads with valid held.
    do_req("wr100", 1'b1, 16'h0100, 32'h11111111, 32'h11111111, 1'b0);
    do_req("wr104", 1'b1, 16'h0104, 32'h22222222, 32'h22222222, 1'b0);
    do_req("rd100", 1'b0, 16'h0100, 32'h0, 32'h11111111, 1'b1);
    c1 = rdy_cyc;
    do_req("rd104", 1'b0, 16'h0104, 32'h0, 32'h22222222, 1'b0);
    chk("b2b_gap", rdy_cyc - c1, 32'd5);

    // Byte offset and address wrap.
    do_req("wr003",  1'b1, 16'h0003, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    do_req("rd000",  1'b0, 16'h0000, 32'h0,        32'hA5A5A5A5, 1'b0);
    do_req("wr4008", 1'b1, 16'h4008, 32'h12345678, 32'h12345678, 1'b0);
    do_req("rd008",  1'b0, 16'h0008, 32'h0,        32'h12345678, 1'b0);

    // Input changes while busy are ignored.
    req_rw    = 1'b0;
    req_addr  = 16'h0010;
    req_data  = 32'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    req_rw   = 1'b1;
    req_addr = 16'h0010;
    req_data = 32'h0;
    wait_ready(1, lat);
    chk("chg_lat",  lat, LAT);
    chk("chg_data", rsp_data, 32'hDEADBEEF);
    req_valid = 1'b0;
    @(posedge clk); #1;
    do_req("chg_rd", 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset in the middle of a write.
    req_rw    = 1'b1;
    req_addr  = 16'h0020;
    req_data  = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, rsp_ready}, 32'd0);
    chk("mrst_data",  rsp_data, 32'd0);
    chk("mrst_state", {30'd0, dbg_state}, 32'd0);
    req_valid = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_ready) pulses++;
    end
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_ready) pulses++;
    end
    chk("mrst_pulses", pulses, 32'd0);
    do_req("mrst_rd20", 1'b0, 16'h0020, 32'h0, 32'h00000000, 1'b0);

    // LATENCY=1 instance: write then read with valid held.
    req_rw     = 1'b1;
    req_addr   = 16'h0040;
    req_data   = 32'h5A5A1234;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    chk("l1_t0_ready", {31'd0, rsp_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("l1_t1_ready", {31'd0, rsp_ready1}, 32'd1);
    chk("l1_t1_data",  rsp_data1, 32'h5A5A1234);
    req_rw   = 1'b0;
    req_data = 32'h0;
    @(posedge clk); #1;
    chk("l1_t2_ready", {31'd0, rsp_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("l1_t3_ready", {31'd0, rsp_ready1}, 32'd1);
    chk("l1_t3_data",  rsp_data1, 32'h5A5A1234);
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_t4_ready", {31'd0, rsp_ready1}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
